// File: rtl/tdp_ram_port_arbiter.sv
// tdp_ram_port_arbiter
//   Purpose : shares one port of a true-dual-port no-change block RAM between
//             NUM_REQ requesters, one access per cycle. Reads are tagged with
//             the requester index and returned through the RAM read latency.
//   Latency : grant and RAM port drive are combinational (same cycle). Read
//             data returns RD_LATENCY cycles after the read is accepted.
//   Backpr. : req_ready is a one-hot grant, withheld by arb_hold or rstb.
//             Responses have no backpressure; sinks take one per cycle.
// Ports:
//   clka, rstb (sync, active-high)          clock / reset
//   arb_hold                                 suppress all grants this cycle
//   req_valid/req_we/req_addr/req_wdata      packed per-requester requests
//   req_ready                                one-hot grant
//   rsp_valid/rsp_id/rsp_rdata               tagged read response
//   ram_en/ram_we/ram_addr/ram_din           RAM port command
//   ram_regce/ram_rst                        RAM output register control
//   ram_dout                                 RAM port read data
// Build option:
//   TDP_ARB_STRICT_PRIO_EN defined -> fixed priority (lowest index wins) and
//   no last-grant register. Undefined (default) -> round-robin.

module tdp_ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic                        clka,
  input  logic                        rstb,
  input  logic                        arb_hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_din,
  output logic                        ram_regce,
  output logic                        ram_rst,
  input  logic [DATA_W-1:0]           ram_dout
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Only the low-latency and high-performance RAM variants exist.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("tdp_ram_port_arbiter: RD_LATENCY must be 1 or 2");
  end

  logic [ID_W-1:0] w_win_idx;
  logic            w_grant;
  logic [ID_W-1:0] w_sel;
  logic            w_rd_acc;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef TDP_ARB_STRICT_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    w_win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_win_idx = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  // Search upward from the slot after the last accepted grant, wrapping.
  always_comb begin
    w_win_idx = '0;
    w_cand    = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // Reset value NUM_REQ-1 makes requester 0 first in line.
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_last_grant <= w_win_idx;
    end
  end
`endif

  // Reset is folded into the grant so nothing reaches the RAM during reset.
  assign w_grant = (|req_valid) & ~arb_hold & ~rstb;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // RAM port drive; idle cycles show slot 0 on address/data (don't-care)
  // ---------------------------------------------------------------------------
  assign w_sel    = w_grant ? w_win_idx : '0;
  assign ram_en   = w_grant;
  assign ram_we   = w_grant & req_we[w_sel];
  assign ram_addr = req_addr[w_sel*ADDR_W +: ADDR_W];
  assign ram_din  = req_wdata[w_sel*DATA_W +: DATA_W];
  assign ram_rst  = rstb;

  // ---------------------------------------------------------------------------
  // Read tag pipeline: one stage per cycle of RAM read latency
  // ---------------------------------------------------------------------------
  assign w_rd_acc = w_grant & ~req_we[w_win_idx];

  logic [RD_LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]       r_tag_id [RD_LATENCY];

  always_ff @(posedge clka) begin
    if (rstb) begin
      // In-flight reads are dropped; they never produce a response.
      r_tag_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld[0] <= w_rd_acc;
      r_tag_id[0]  <= w_rd_acc ? w_win_idx : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign rsp_valid = r_tag_vld[RD_LATENCY-1];
  assign rsp_id    = r_tag_id[RD_LATENCY-1];
  // Data validity is tied to the tag only; a no-change RAM holds dout on writes.
  assign rsp_rdata = ram_dout;

  // The output register only exists on the two-cycle RAM; clock it exactly in
  // the cycle a read sits in the first tag stage.
  if (RD_LATENCY == 2) begin : g_regce
    assign ram_regce = r_tag_vld[0];
  end else begin : g_no_regce
    assign ram_regce = 1'b0;
  end

endmodule

// File: tb/tb_tdp_ram_port_arbiter.sv
module tb_tdp_ram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 18;
`ifdef TDP_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clka = 1'b0;
  logic rstb, arb_hold;
  logic [NR-1:0]    req_valid, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;

  // RD_LATENCY = 2 instance
  logic [NR-1:0] req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          ram_en, ram_we, ram_regce, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  // RD_LATENCY = 1 instance, same stimulus
  logic [NR-1:0] req_ready_l1;
  logic          rsp_valid_l1;
  logic [1:0]    rsp_id_l1;
  logic [DW-1:0] rsp_rdata_l1;
  logic          ram_en_l1, ram_we_l1, ram_regce_l1, ram_rst_l1;
  logic [AW-1:0] ram_addr_l1;
  logic [DW-1:0] ram_din_l1, ram_dout_l1;

  int n_tests, n_fail;

  always #5 clka = ~clka;

  tdp_ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut (
    .clka(clka), .rstb(rstb), .arb_hold(arb_hold),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout)
  );

  tdp_ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut1 (
    .clka(clka), .rstb(rstb), .arb_hold(arb_hold),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready_l1), .rsp_valid(rsp_valid_l1), .rsp_id(rsp_id_l1), .rsp_rdata(rsp_rdata_l1),
    .ram_en(ram_en_l1), .ram_we(ram_we_l1), .ram_addr(ram_addr_l1), .ram_din(ram_din_l1),
    .ram_regce(ram_regce_l1), .ram_rst(ram_rst_l1), .ram_dout(ram_dout_l1)
  );

  // No-change RAM model: array write on write cycles, latch updated on reads
  // only, optional output register behind regce / rst.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q, rd_q1;

  always @(posedge clka) begin
    if (ram_en && ram_we)  mem[ram_addr] <= ram_din;
    if (ram_en && !ram_we) rd_q <= mem[ram_addr];
    if (ram_rst)           ram_dout <= '0;
    else if (ram_regce)    ram_dout <= rd_q;
    if (ram_en_l1 && !ram_we_l1) rd_q1 <= mem[ram_addr_l1];
  end
  assign ram_dout_l1 = rd_q1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  logic [DW-1:0] exp_d [3];
  logic [NR-1:0] exp_rdy;
  int            exp_idx;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_d[0] = 18'h11111;
    exp_d[1] = 18'h22222;
    exp_d[2] = 18'h33333;
    mem[5] = 18'h01234;
    mem[1] = exp_d[0];
    mem[2] = exp_d[1];
    mem[3] = exp_d[2];
    rstb = 1'b1; arb_hold = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // ---- reset: all valid but nothing granted
    step();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10'd5, '0);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_rst", ram_rst, 1);
    chk("rst_ram_rst_l1", ram_rst_l1, 1);
    step();
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_regce", ram_regce, 0);
    chk("rst_rsp_valid_l1", rsp_valid_l1, 0);

    // ---- single read, req 0, addr 0x005
    rstb = 1'b0;
    set_req(0, 1'b0, 10'h005, '0);
    #1;
    chk("rd0_ready", req_ready, 4'b0001);
    chk("rd0_ram_en", ram_en, 1);
    chk("rd0_ram_we", ram_we, 0);
    chk("rd0_ram_addr", ram_addr, 10'h005);
    chk("rd0_ram_rst", ram_rst, 0);
    step();
    req_valid = '0;
    #1;
    chk("rd0_regce_t1", ram_regce, 1);
    chk("rd0_rsp_valid_t1", rsp_valid, 0);
    chk("rd0_l1_valid", rsp_valid_l1, 1);
    chk("rd0_l1_id", rsp_id_l1, 0);
    chk("rd0_l1_data", rsp_rdata_l1, 18'h01234);
    chk("rd0_l1_regce", ram_regce_l1, 0);
    step();
    chk("rd0_rsp_valid_t2", rsp_valid, 1);
    chk("rd0_rsp_id_t2", rsp_id, 0);
    chk("rd0_rsp_data_t2", rsp_rdata, 18'h01234);
    chk("rd0_regce_t2", ram_regce, 0);
    step();
    chk("rd0_rsp_valid_t3", rsp_valid, 0);

    // ---- all four valid for 8 cycles, fresh reset first
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10'd5, '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_idx = STRICT ? 0 : (k % NR);
      exp_rdy = 4'b0001 << exp_idx;
      chk($sformatf("rr_ready_%0d", k), req_ready, exp_rdy);
      if (k >= 2) begin
        chk($sformatf("rr_rsp_valid_%0d", k), rsp_valid, 1);
        chk($sformatf("rr_rsp_id_%0d", k), rsp_id, STRICT ? 0 : ((k - 2) % NR));
        chk($sformatf("rr_rsp_data_%0d", k), rsp_rdata, 18'h01234);
      end
      step();
    end
    req_valid = '0;
    step(); step(); step();

    // ---- write 0x00ABC to 0x3FF by req 1, then read back by req 2
    set_req(1, 1'b1, 10'h3FF, 18'h00ABC);
    #1;
    chk("wr_ready", req_ready, 4'b0010);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 10'h3FF);
    chk("wr_ram_din", ram_din, 18'h00ABC);
    chk("wr_ram_din_l1", ram_din_l1, 18'h00ABC);
    step();
    req_valid = '0;
    set_req(2, 1'b0, 10'h3FF, '0);
    #1;
    chk("rbk_ready", req_ready, 4'b0100);
    chk("rbk_ram_we", ram_we, 0);
    chk("wr_no_rsp_l1", rsp_valid_l1, 0);
    step();
    req_valid = '0;
    #1;
    chk("wr_no_rsp", rsp_valid, 0);
    chk("rbk_regce", ram_regce, 1);
    chk("rbk_l1_valid", rsp_valid_l1, 1);
    chk("rbk_l1_id", rsp_id_l1, 2);
    chk("rbk_l1_data", rsp_rdata_l1, 18'h00ABC);
    step();
    chk("rbk_rsp_valid", rsp_valid, 1);
    chk("rbk_rsp_id", rsp_id, 2);
    chk("rbk_rsp_data", rsp_rdata, 18'h00ABC);
    step();

    // ---- back-to-back reads from req 3 at addrs 1,2,3
    for (int c = 0; c < 6; c++) begin
      req_valid = '0;
      if (c < 3) set_req(3, 1'b0, AW'(c + 1), '0);
      #1;
      if (c < 3) begin
        chk($sformatf("b2b_ready_%0d", c), req_ready, 4'b1000);
        chk($sformatf("b2b_ready_l1_%0d", c), req_ready_l1, 4'b1000);
      end
      chk($sformatf("b2b_regce_l1_%0d", c), ram_regce_l1, 0);
      if (c >= 1 && c <= 3) begin
        chk($sformatf("b2b_l1_valid_%0d", c), rsp_valid_l1, 1);
        chk($sformatf("b2b_l1_id_%0d", c), rsp_id_l1, 3);
        chk($sformatf("b2b_l1_data_%0d", c), rsp_rdata_l1, exp_d[c-1]);
      end else begin
        chk($sformatf("b2b_l1_idle_%0d", c), rsp_valid_l1, 0);
      end
      if (c >= 2 && c <= 4) begin
        chk($sformatf("b2b_valid_%0d", c), rsp_valid, 1);
        chk($sformatf("b2b_id_%0d", c), rsp_id, 3);
        chk($sformatf("b2b_data_%0d", c), rsp_rdata, exp_d[c-2]);
      end else begin
        chk($sformatf("b2b_idle_%0d", c), rsp_valid, 0);
      end
      step();
    end

    // ---- two reads in flight, then a one-cycle reset
    req_valid = '0;
    set_req(0, 1'b0, 10'd5, '0);
    #1;
    chk("fl_ready0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    set_req(1, 1'b0, 10'd5, '0);
    #1;
    chk("fl_ready1", req_ready, 4'b0010);
    step();
    rstb = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10'd5, '0);
    #1;
    chk("fl_rst_ready", req_ready, 0);
    chk("fl_rst_ram_en", ram_en, 0);
    chk("fl_rst_ram_we", ram_we, 0);
    chk("fl_rst_ram_rst", ram_rst, 1);
    step();
    rstb = 1'b0;
    req_valid = '0;
    #1;
    chk("fl_post_rsp_valid", rsp_valid, 0);
    chk("fl_post_rsp_id", rsp_id, 0);
    chk("fl_post_regce", ram_regce, 0);
    chk("fl_post_rsp_valid_l1", rsp_valid_l1, 0);
    chk("fl_post_ready", req_ready, 0);
    chk("fl_post_ram_en", ram_en, 0);
    chk("fl_post_ram_we", ram_we, 0);
    step();
    chk("fl_post2_rsp_valid", rsp_valid, 0);
    chk("fl_post2_rsp_valid_l1", rsp_valid_l1, 0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10'd5, '0);
    #1;
    chk("fl_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step(); step(); step();

    // ---- arb_hold for 3 cycles with req 2 valid; earlier read still returns
    set_req(1, 1'b0, 10'd5, '0);
    #1;
    chk("hold_pre_ready", req_ready, 4'b0010);
    step();
    for (int h = 0; h < 3; h++) begin
      arb_hold  = 1'b1;
      req_valid = '0;
      set_req(2, 1'b0, 10'd5, '0);
      #1;
      chk($sformatf("hold_ready_%0d", h), req_ready, 0);
      chk($sformatf("hold_ram_en_%0d", h), ram_en, 0);
      if (h == 0) chk("hold_regce", ram_regce, 1);
      if (h == 1) begin
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_id", rsp_id, 1);
      end
      step();
    end
    arb_hold = 1'b0;
    #1;
    chk("hold_release_ready", req_ready, 4'b0100);
    chk("hold_release_ram_en", ram_en, 1);
    step();
    req_valid = '0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
